// File: rtl/cla_serial_wide_adder_pkg.sv
// rtl/cla_serial_wide_adder_pkg.sv - shared types and constants for the serial CLA adder
package cla_serial_wide_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Index counter width; a single-nibble adder still needs a 1-bit counter.
    function automatic int idx_width(input int nibbles);
        idx_width = (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/cla_serial_wide_adder_if.sv
// rtl/cla_serial_wide_adder_if.sv - operand/result handshake bundle for the serial CLA adder
interface cla_serial_wide_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, busy
    );
endinterface

// File: rtl/cla_serial_wide_adder_cla4_slice.sv
// rtl/cla_serial_wide_adder_cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_c3,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a | i_b;

    // Every carry is expanded straight from g/p/cin, no ripple between bits.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = i_a ^ i_b ^ w_c[3:0];
    assign o_c3   = w_c[3];
    assign o_cout = w_c[4];
endmodule

// File: rtl/cla_serial_wide_adder.sv
// rtl/cla_serial_wide_adder.sv - WIDTH-bit adder sequencing one shared 4-bit CLA slice, LSB nibble first
module cla_serial_wide_adder
    import cla_serial_wide_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_serial_wide_adder_if.slave  bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_s;
    logic             w_c3;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    cla4_slice u_slice (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_c3   (w_c3),
        .o_cout (w_cout)
    );

    assign w_last     = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_sum_next = (r_sum >> NIBBLE_W) | (WIDTH'(w_s) << (WIDTH - NIBBLE_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.c_in;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    // Top nibble: its carries decide the final flags.
                    if (w_last) begin
                        r_cout <= w_cout;
                        r_ovf  <= w_c3 ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_cout;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_cla_serial_wide_adder.sv
// tb/tb_cla_serial_wide_adder.sv - directed self-checking bench for the serial CLA adder
module tb_cla_serial_wide_adder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cla_serial_wide_adder_if #(.WIDTH(32)) if32 ();
    cla_serial_wide_adder_if #(.WIDTH(4))  if4 ();

    cla_serial_wide_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    cla_serial_wide_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic cin);
        int k;
        k = 0;
        while (!if32.in_ready && k < 50) begin
            step();
            k++;
        end
        check("issue_ready", 64'(if32.in_ready), 64'd1);
        if32.a = a;
        if32.b = b;
        if32.c_in = cin;
        if32.in_valid = 1'b1;
        step();
        if32.in_valid = 1'b0;
    endtask

    task automatic wait_done32(output int lat);
        lat = 0;
        while (!if32.out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic release32();
        if32.out_ready = 1'b1;
        step();
        if32.out_ready = 1'b0;
        check("release_in_ready", 64'(if32.in_ready), 64'd1);
        check("release_out_valid", 64'(if32.out_valid), 64'd0);
    endtask

    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [31:0] exp_s, input logic exp_co, input logic exp_ov);
        int lat;
        issue32(a, b, cin);
        wait_done32(lat);
        check({tag, "_lat"}, 64'(lat), 64'd8);
        check({tag, "_sum"}, 64'(if32.sum), 64'(exp_s));
        check({tag, "_cout"}, 64'(if32.c_out), 64'(exp_co));
        check({tag, "_ovf"}, 64'(if32.overflow), 64'(exp_ov));
        release32();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] full;
        logic [31:0] held;
        int          lat;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.c_in = 1'b0; if32.out_ready = 1'b0;
        if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.c_in  = 1'b0; if4.out_ready  = 1'b0;
        step();
        step();
        check("rst_in_ready", 64'(if32.in_ready), 64'd1);
        check("rst_out_valid", 64'(if32.out_valid), 64'd0);
        check("rst_sum", 64'(if32.sum), 64'd0);
        check("rst_busy", 64'(if32.busy), 64'd0);
        rst = 1'b0;
        step();

        op32("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        op32("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op32("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        op32("max_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Carry-in plus a five-cycle result stall with stray in_valid pulses.
        issue32(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        wait_done32(lat);
        check("stall_lat", 64'(lat), 64'd8);
        check("stall_sum", 64'(if32.sum), 64'h2222_2222);
        check("stall_cout", 64'(if32.c_out), 64'd0);
        check("stall_ovf", 64'(if32.overflow), 64'd0);
        for (int i = 0; i < 5; i++) begin
            if32.in_valid = i[0];
            if32.a = 32'hDEAD_BEEF;
            step();
            check("stall_hold_sum", 64'(if32.sum), 64'h2222_2222);
            check("stall_in_ready", 64'(if32.in_ready), 64'd0);
            check("stall_out_valid", 64'(if32.out_valid), 64'd1);
        end
        if32.in_valid = 1'b0;
        release32();
        check("stall_kept_sum", 64'(if32.sum), 64'h2222_2222);
        step();
        step();
        check("stall_no_ghost_busy", 64'(if32.busy), 64'd0);

        // Abort an operation three RUN cycles in.
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step();
        step();
        step();
        check("abort_busy", 64'(if32.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(if32.in_ready), 64'd1);
        check("abort_out_valid", 64'(if32.out_valid), 64'd0);
        check("abort_sum", 64'(if32.sum), 64'd0);
        check("abort_cout", 64'(if32.c_out), 64'd0);
        check("abort_ovf", 64'(if32.overflow), 64'd0);
        check("abort_busy_low", 64'(if32.busy), 64'd0);
        step();
        rst = 1'b0;
        step();
        op32("after_abort", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

        // Single-nibble instance.
        if4.a = 4'hF;
        if4.b = 4'hF;
        if4.c_in = 1'b1;
        if4.in_valid = 1'b1;
        step();
        if4.in_valid = 1'b0;
        check("w4_run", 64'(if4.out_valid), 64'd0);
        step();
        check("w4_valid", 64'(if4.out_valid), 64'd1);
        check("w4_sum", 64'(if4.sum), 64'hF);
        check("w4_cout", 64'(if4.c_out), 64'd1);
        check("w4_ovf", 64'(if4.overflow), 64'd0);
        if4.out_ready = 1'b1;
        step();
        if4.out_ready = 1'b0;
        check("w4_idle", 64'(if4.in_ready), 64'd1);

        // Random operands with random result stalls against a+b+c_in.
        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            issue32(ra, rb, rc);
            wait_done32(lat);
            check("rnd_lat", 64'(lat), 64'd8);
            held = if32.sum;
            repeat ($urandom_range(0, 3)) step();
            check("rnd_sum", 64'(if32.sum), 64'(full[31:0]));
            check("rnd_sum_stable", 64'(if32.sum), 64'(held));
            check("rnd_cout", 64'(if32.c_out), 64'(full[32]));
            check("rnd_ovf", 64'(if32.overflow),
                  64'((ra[31] == rb[31]) && (full[31] != ra[31])));
            release32();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
